serial_tx_arbiter: RTL
======================

// Module: serial_tx_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares the single 32-bit serial transmitter between N_REQ requesters.
//  Picks one pending word, issues a 1-cycle load pulse with data held stable, and tracks the frame via data_enable.
//  Grants again only after the frame ends. Sits between producer blocks and the serial transmitter, same sclk domain.
// PARAMETERS
//  N_REQ        4    number of requesters (2..8)
//  DATA_W       32   word width; must equal transmitter width
//  TIMEOUT_CYC  48   max sclk cycles from load pulse to data_enable fall (SERIAL_ARB_TIMEOUT_EN only)
// PORTS
//  sclk             in   1             serial clock, single clock domain, all logic posedge
//  rst_n            in   1             asynchronous active-low reset
//  req              in   N_REQ         per-requester request; hold high until matching ack
//  req_data         in   N_REQ*DATA_W  word i at [i*DATA_W +: DATA_W]
//  ack              out  N_REQ         1-cycle pulse: word i captured and being sent
//  grant_id         out  $clog2(N_REQ) index of current/last granted requester
//  busy             out  1             high from grant until transmitter frame end
//  ser_load_data    out  1             load pulse to transmitter
//  ser_data_in      out  DATA_W        word to transmitter; stable from load pulse to frame end
//  ser_data_enable  in   1             transmitter data_enable (frame in progress)
//  timeout_err      out  1             1-cycle pulse on watchdog abort (0 without macro)
// BEHAVIOUR
//  Reset: ack=0, grant_id=0, busy=0, ser_load_data=0, ser_data_in=0, timeout_err=0, FSM=IDLE, rr pointer=0.
//  All outputs registered. FSM states and transitions:
//   IDLE:   if |req && !ser_data_enable -> LOAD
//           Winner = first set req at or after rr pointer (wrapping N_REQ-1 -> 0).
//           Capture req_data[winner] into ser_data_in; grant_id=winner.
//           rr pointer = winner+1 mod N_REQ.
//   LOAD:   ser_load_data=1 and ack[grant_id]=1 for exactly this cycle; busy=1 -> WAIT_START.
//   WAIT_START: ser_load_data=0; wait for ser_data_enable=1 -> WAIT_DONE.
//   WAIT_DONE:  wait for ser_data_enable=0 -> IDLE; busy=0 on that transition.
//  Latency: req seen in IDLE -> ack/load pulse 1 cycle later.
//   Transmitter raises data_enable 2 cycles after the pulse and keeps it for 32 cycles.
//   Next grant needs at least 1 IDLE cycle after the fall.
//  ser_data_in changes only on the IDLE->LOAD edge; never while busy.
//  Starvation-free: with all req high, grants cycle 0,1,2,3,0...
//  Simultaneous requests are resolved only by the rr pointer; new req during busy waits.
//  Requester dropping req before ack: word already captured is still sent and acked (protocol violation, not checked).
//  Same requester holding req after ack is treated as a new request, subject to rr order.
//  Reset mid-frame: FSM to IDLE immediately. Transmitter has no reset and may still be sending.
//   IDLE therefore never grants while ser_data_enable=1.
// CONFIGURATION
//  SERIAL_ARB_TIMEOUT_EN defined:
//   Counter starts at LOAD and runs through WAIT_START/WAIT_DONE.
//   If it reaches TIMEOUT_CYC, FSM goes to IDLE, busy=0, timeout_err pulses 1 cycle, rr pointer kept.
//   ack for the aborted word has already been given.
//  Undefined: no counter; timeout_err tied 0; FSM waits indefinitely in WAIT_START/WAIT_DONE.
// STRUCTURE
//  serial_arb_pkg: FSM state encodings (IDLE, LOAD, WAIT_START, WAIT_DONE), default DATA_W/N_REQ, ID width function.
//  Sub-module rr_arbiter (req vector + pointer -> one-hot/index winner, combinational).
//  Sequencing FSM, data capture and watchdog stay in serial_tx_arbiter.
// TESTING
//  Bench models the transmitter (data_enable high 32 cycles, starting 2 cycles after load).
//  1 Single word: req[2]=1, req_data[2]=32'hDEADBEEF.
//     -> ack[2] one cycle later, ser_load_data 1-cycle pulse, ser_data_in=DEADBEEF held until data_enable falls.
//  2 All req held high, 8 frames -> grant_id sequence 0,1,2,3,0,1,2,3; exactly one ack per frame.
//  3 req[1] rises while busy with req[3] -> no second load pulse until data_enable falls; then grant_id=1.
//  4 Reset asserted mid-frame with model data_enable=1 -> outputs 0 at once;
//     after release, no load pulse until data_enable=0.
//  5 SERIAL_ARB_TIMEOUT_EN, model never raises data_enable -> timeout_err pulse 48 cycles after load; busy=0; next req granted.
//  6 Without macro, same stimulus -> timeout_err stays 0, busy stays 1, no further grants.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg: shared types, defaults and helpers for the serial transmitter arbiter.
package serial_arb_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StLoad      = 2'd1,
        StWaitStart = 2'd2,
        StWaitDone  = 2'd3
    } arb_state_e;

    localparam int unsigned DefNReq       = 4;
    localparam int unsigned DefDataW      = 32;
    localparam int unsigned DefTimeoutCyc = 48;

    // Width of a requester index; never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if: requester side and transmitter side signals of the arbiter.
// The arbiter uses the slave modport; the producer/transmitter environment uses master.
interface serial_tx_arbiter_if
    import serial_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = DefNReq,
    parameter int unsigned DATA_W = DefDataW
);
    localparam int unsigned IdW = id_width(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic [IdW-1:0]          grant_id;
    logic                    busy;
    logic                    ser_load_data;
    logic [DATA_W-1:0]       ser_data_in;
    logic                    ser_data_enable;
    logic                    timeout_err;

    modport slave (
        input  req, req_data, ser_data_enable,
        output ack, grant_id, busy, ser_load_data, ser_data_in, timeout_err
    );

    modport master (
        output req, req_data, ser_data_enable,
        input  ack, grant_id, busy, ser_load_data, ser_data_in, timeout_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Returns the first set request at or
// after the pointer, wrapping from N_REQ-1 back to 0.
module rr_arbiter
    import serial_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq
) (
    input  logic [N_REQ-1:0]           i_req,
    input  logic [id_width(N_REQ)-1:0] i_ptr,
    output logic                       o_valid,
    output logic [id_width(N_REQ)-1:0] o_idx,
    output logic [N_REQ-1:0]           o_onehot
);
    localparam int unsigned IdW = id_width(N_REQ);

    logic [IdW-1:0] w_pos;

    // Scan upward from the pointer and keep the first pending requester.
    always_comb begin
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_pos    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_pos = IdW'((32'(i_ptr) + k) % N_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end
        end
        if (o_valid) o_onehot[o_idx] = 1'b1;
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sequencer sharing one serial transmitter among N_REQ
// requesters. Grants one word, pulses load/ack for a cycle, then tracks the frame via
// ser_data_enable. Optional watchdog enabled by defining SERIAL_ARB_TIMEOUT_EN.
module serial_tx_arbiter
    import serial_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = DefNReq,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input logic                sclk,
    input logic                rst_n,
    serial_tx_arbiter_if.slave bus
);
    localparam int unsigned IdW = id_width(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 3) begin : g_bad_cfg
        $error("serial_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 3");
    end

    arb_state_e        r_state, w_state_nxt;
    logic [IdW-1:0]    r_ptr, w_ptr_nxt;
    logic [IdW-1:0]    r_grant_id, w_grant_id_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [N_REQ-1:0]  r_ack, w_ack_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_load, w_load_nxt;

    logic              w_win_valid;
    logic [IdW-1:0]    w_win_idx;
    logic [N_REQ-1:0]  w_win_onehot;
    logic [DATA_W-1:0] w_win_data;

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic            r_tmo_err, w_tmo_err_nxt;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_valid  (w_win_valid),
        .o_idx    (w_win_idx),
        .o_onehot (w_win_onehot)
    );

    // Select the winner's word out of the flattened request data bus.
    always_comb begin
        w_win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_win_idx == IdW'(i)) w_win_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Next state and next registered outputs of the sequencing FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_id_nxt = r_grant_id;
        w_data_nxt     = r_data;
        w_ack_nxt      = '0;
        w_busy_nxt     = r_busy;
        w_load_nxt     = 1'b0;
`ifdef SERIAL_ARB_TIMEOUT_EN
        w_cnt_nxt      = r_cnt + 1'b1;
        w_tmo_err_nxt  = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
`ifdef SERIAL_ARB_TIMEOUT_EN
                w_cnt_nxt = '0;
`endif
                // The transmitter is not reset with us, so never grant into a live frame.
                if (w_win_valid && !bus.ser_data_enable) begin
                    w_state_nxt    = StLoad;
                    w_data_nxt     = w_win_data;
                    w_grant_id_nxt = w_win_idx;
                    w_ptr_nxt      = (w_win_idx == IdW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
                    w_ack_nxt      = w_win_onehot;
                    w_load_nxt     = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            StLoad: begin
                w_state_nxt = StWaitStart;
            end
            StWaitStart: begin
                if (bus.ser_data_enable) w_state_nxt = StWaitDone;
            end
            StWaitDone: begin
                if (!bus.ser_data_enable) begin
                    w_state_nxt = StIdle;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
`ifdef SERIAL_ARB_TIMEOUT_EN
        // Abort a frame that never completes; the word was already acked.
        if (r_state != StIdle && w_state_nxt != StIdle && r_cnt == CntLast) begin
            w_state_nxt   = StIdle;
            w_busy_nxt    = 1'b0;
            w_tmo_err_nxt = 1'b1;
        end
`endif
    end

    // FSM state, round-robin pointer and all registered outputs.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_data     <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_data     <= w_data_nxt;
            r_ack      <= w_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_load     <= w_load_nxt;
        end
    end

`ifdef SERIAL_ARB_TIMEOUT_EN
    // Watchdog counter and its error pulse.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    assign bus.timeout_err = r_tmo_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.ack           = r_ack;
    assign bus.grant_id      = r_grant_id;
    assign bus.busy          = r_busy;
    assign bus.ser_load_data = r_load;
    assign bus.ser_data_in   = r_data;

endmodule
